// File: rtl/tick_timer.sv
// Programmable down-counting tick timer: counts a loaded number of divider ticks,
// then strobes expire for one cycle, in one-shot or auto-reload mode.
module tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             periodic,
    input  logic             stop,
    output logic             busy,
    output logic             expire,
    output logic [WIDTH-1:0] count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q,   mode_d;
    logic             expire_q, expire_d;

    // Next-state logic; priority is stop > start > tick, and a tick on a start edge is dropped.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        expire_d = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            count_d = ZERO;
        end else if (start) begin
            if (load_val != ZERO) begin
                state_d  = ST_RUN;
                count_d  = load_val;
                reload_d = load_val;
                mode_d   = periodic;
            end else begin
                state_d  = ST_IDLE;
                count_d  = ZERO;
                expire_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tick) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else begin
                            // Terminal tick: reload is immediate so periodic expires stay N ticks apart.
                            expire_d = 1'b1;
                            if (mode_q) begin
                                count_d = reload_q;
                            end else begin
                                count_d = ZERO;
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                ST_IDLE: begin
                    count_d = ZERO;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = ZERO;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign expire = expire_q;
    assign count  = count_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: reset, one-shot, periodic, zero load, restart/abort
// and a full-range countdown with tick held high.
module tb_tick_timer;

    logic       clk = 1'b0;
    logic       reset, tick, start, periodic, stop;
    logic [7:0] load_val;
    logic       busy, expire;
    logic [7:0] count;

    int checks = 0;
    int errors = 0;

    tick_timer #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .load_val (load_val),
        .periodic (periodic),
        .stop     (stop),
        .busy     (busy),
        .expire   (expire),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic idle3(inout int exp_seen);
        for (int j = 0; j < 3; j++) begin
            step();
            exp_seen += int'(expire);
        end
    endtask

    initial begin
        int seen;
        int bad;
        time t_last;
        time t_gap_bad;

        reset = 1'b1; tick = 1'b0; start = 1'b0; periodic = 1'b0; stop = 1'b0; load_val = 8'd0;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_expire", expire, 0);

        // 1: reset mid-run
        start = 1'b1; load_val = 8'd5;
        step();
        start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_count", count, 5);
        pulse(); step(); step(); step();
        pulse();
        chk("t1_count_after2", count, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_count", count, 0);
        chk("t1_rst_expire", expire, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            pulse();
            seen += int'(expire) + int'(busy) + int'(count != 8'd0);
        end
        chk("t1_ticks_ignored", seen, 0);

        // 2: one-shot load 3
        start = 1'b1; load_val = 8'd3; periodic = 1'b0;
        step();
        start = 1'b0;
        chk("t2_count3", count, 3);
        seen = 0;
        step(); step(); step();
        pulse();
        chk("t2_count2", count, 2);
        chk("t2_noexp2", expire, 0);
        idle3(seen);
        pulse();
        chk("t2_count1", count, 1);
        idle3(seen);
        chk("t2_no_early_expire", seen, 0);
        pulse();
        chk("t2_count0", count, 0);
        chk("t2_expire", expire, 1);
        chk("t2_busy_fall", busy, 0);
        step();
        chk("t2_expire_once", expire, 0);

        // 3: periodic load 2, 7 ticks
        start = 1'b1; load_val = 8'd2; periodic = 1'b1;
        step();
        start = 1'b0;
        chk("t3_count_init", count, 2);
        seen = 0; bad = 0; t_last = 0; t_gap_bad = 0;
        for (int k = 1; k <= 7; k++) begin
            idle3(seen);
            pulse();
            if (expire) begin
                if (t_last != 0 && ($time - t_last) != 80) t_gap_bad++;
                t_last = $time;
            end
            seen += int'(expire);
            if (expire !== ((k % 2) == 0)) bad++;
            if (count !== (((k % 2) == 0) ? 8'd2 : 8'd1)) bad++;
            if (busy !== 1'b1) bad++;
        end
        idle3(seen);
        chk("t3_expire_count", seen, 3);
        chk("t3_seq", bad, 0);
        chk("t3_gap_8clk", t_gap_bad, 0);
        chk("t3_busy", busy, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t3_stop_busy", busy, 0);
        chk("t3_stop_count", count, 0);

        // 4: zero load
        start = 1'b1; load_val = 8'd0; periodic = 1'b0;
        step();
        start = 1'b0;
        chk("t4_expire", expire, 1);
        chk("t4_busy", busy, 0);
        chk("t4_count", count, 0);
        step();
        chk("t4_expire_drop", expire, 0);
        chk("t4_busy_after", busy, 0);

        // 5: restart with concurrent tick, then stop on terminal tick
        start = 1'b1; load_val = 8'd5; periodic = 1'b0;
        step();
        start = 1'b0;
        pulse();
        chk("t5_count4", count, 4);
        start = 1'b1; tick = 1'b1; load_val = 8'd6;
        step();
        start = 1'b0; tick = 1'b0;
        chk("t5_restart_count", count, 6);
        chk("t5_restart_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            pulse();
        end
        chk("t5_count1", count, 1);
        tick = 1'b1; stop = 1'b1;
        step();
        tick = 1'b0; stop = 1'b0;
        chk("t5_abort_expire", expire, 0);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_count", count, 0);
        step();
        chk("t5_abort_expire_late", expire, 0);

        // 6: 255 ticks, tick held high from the start edge
        start = 1'b1; load_val = 8'd255; periodic = 1'b0; tick = 1'b1;
        step();
        start = 1'b0;
        chk("t6_count_init", count, 255);
        bad = 0;
        for (int i = 1; i <= 254; i++) begin
            step();
            if (count !== 8'(255 - i)) bad++;
            if (expire !== 1'b0) bad++;
            if (busy !== 1'b1) bad++;
        end
        chk("t6_countdown", bad, 0);
        step();
        chk("t6_expire", expire, 1);
        chk("t6_count0", count, 0);
        chk("t6_busy", busy, 0);
        step();
        chk("t6_expire_once", expire, 0);
        chk("t6_no_wrap", count, 0);
        tick = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
